// File: rtl/bmc_soft_pipe.sv
// bmc_soft_pipe: pipelined branch metric unit for a rate 1/N Viterbi decoder.
// Computes the distance of one received symbol to every one of the 2^N branch
// codewords. Supports soft or hard decision and per-bit erasure.
// Optional build macro BMC_NORM_EN adds a third stage that subtracts the
// smallest metric from all metrics, so the best codeword reads as 0.
module bmc_soft_pipe #(
  parameter int N      = 2,
  parameter int SOFT_W = 3,
  localparam int MW    = $clog2(N * (2**SOFT_W - 1) + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*SOFT_W-1:0]     rx_sym,
  input  logic [N-1:0]            rx_erase,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [(2**N)*MW-1:0]    bm,
  output logic [15:0]             sym_cnt
);

  localparam int NK = 2**N;
  localparam logic [SOFT_W-1:0] SMAX = {SOFT_W{1'b1}};

  // Distance of one soft bit to an expected code bit; erased bits carry no information.
  function automatic logic [SOFT_W-1:0] f_dist(input logic [SOFT_W-1:0] s,
                                               input logic e,
                                               input logic era);
    if (era) return '0;
    return e ? (SMAX - s) : s;
  endfunction

  logic                         w_ld1;
  logic                         w_ld2;
  logic                         w_in_xfer;
  logic                         w_vld_out;
  logic [NK-1:0][MW-1:0]        w_bm_out;
  logic [NK-1:0][MW-1:0]        w_sum_p1;

  logic                         r_vld_p1;
  logic [N-1:0][SOFT_W-1:0]     r_d0_p1;
  logic [N-1:0][SOFT_W-1:0]     r_d1_p1;
  logic                         r_vld_p2;
  logic [NK-1:0][MW-1:0]        r_sum_p2;
  logic [15:0]                  r_sym_cnt;

  assign w_ld1     = ~r_vld_p1 | w_ld2;
  assign in_ready  = w_ld1 & ~rst;
  assign w_in_xfer = in_valid & in_ready;

  // ---- stage 1: per-bit distances for both expected polarities ----

  // Stage 1 valid follows the input whenever the stage is free to load.
  always_ff @(posedge clk) begin
    if (rst)        r_vld_p1 <= 1'b0;
    else if (w_ld1) r_vld_p1 <= in_valid;
  end

  // Stage 1 data is captured only on an accepted symbol.
  always_ff @(posedge clk) begin
    if (w_in_xfer) begin
      for (int i = 0; i < N; i++) begin
        r_d0_p1[i] <= f_dist(rx_sym[i*SOFT_W +: SOFT_W], 1'b0, rx_erase[i]);
        r_d1_p1[i] <= f_dist(rx_sym[i*SOFT_W +: SOFT_W], 1'b1, rx_erase[i]);
      end
    end
  end

  // Sum the selected polarity of every bit for each codeword k (bit i of k = expected bit i).
  always_comb begin
    w_sum_p1 = '0;
    for (int k = 0; k < NK; k++) begin
      for (int i = 0; i < N; i++) begin
        w_sum_p1[k] = w_sum_p1[k] +
                      {{(MW-SOFT_W){1'b0}}, (k[i] ? r_d1_p1[i] : r_d0_p1[i])};
      end
    end
  end

  // ---- stage 2: codeword sums ----

  // Stage 2 valid advances whenever stage 2 may load.
  always_ff @(posedge clk) begin
    if (rst)        r_vld_p2 <= 1'b0;
    else if (w_ld2) r_vld_p2 <= r_vld_p1;
  end

`ifdef BMC_NORM_EN
  logic                  w_ld3;
  logic [MW-1:0]         w_min_p2;
  logic                  r_vld_p3;
  logic [NK-1:0][MW-1:0] r_bm_p3;

  assign w_ld3 = ~r_vld_p3 | out_ready;
  assign w_ld2 = ~r_vld_p2 | w_ld3;

  // Stage 2 data holds the raw sums feeding the normaliser.
  always_ff @(posedge clk) begin
    if (w_ld2 && r_vld_p1) r_sum_p2 <= w_sum_p1;
  end

  // Smallest raw metric of the symbol held in stage 2.
  always_comb begin
    w_min_p2 = r_sum_p2[0];
    for (int k = 1; k < NK; k++) begin
      if (r_sum_p2[k] < w_min_p2) w_min_p2 = r_sum_p2[k];
    end
  end

  // ---- stage 3: normalised output register ----

  // Output valid advances whenever the output register may load.
  always_ff @(posedge clk) begin
    if (rst)        r_vld_p3 <= 1'b0;
    else if (w_ld3) r_vld_p3 <= r_vld_p2;
  end

  // Output metrics are rebased so the best codeword reads 0; cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bm_p3 <= '0;
    end else if (w_ld3 && r_vld_p2) begin
      for (int k = 0; k < NK; k++) r_bm_p3[k] <= r_sum_p2[k] - w_min_p2;
    end
  end

  assign w_vld_out = r_vld_p3;
  assign w_bm_out  = r_bm_p3;
`else
  assign w_ld2 = ~r_vld_p2 | out_ready;

  // Stage 2 is the output register for the raw metrics; cleared on reset.
  always_ff @(posedge clk) begin
    if (rst)                    r_sum_p2 <= '0;
    else if (w_ld2 && r_vld_p1) r_sum_p2 <= w_sum_p1;
  end

  assign w_vld_out = r_vld_p2;
  assign w_bm_out  = r_sum_p2;
`endif

  // Count accepted symbols; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst)            r_sym_cnt <= '0;
    else if (w_in_xfer) r_sym_cnt <= r_sym_cnt + 16'd1;
  end

  // No output handshake may complete while reset is asserted.
  assign out_valid = w_vld_out & ~rst;
  assign bm        = w_bm_out;
  assign sym_cnt   = r_sym_cnt;

endmodule

// File: tb/tb_bmc_soft_pipe.sv
// Testbench for bmc_soft_pipe: soft instance (N=2, SOFT_W=3) and hard-decision
// instance (N=2, SOFT_W=1). Works with or without BMC_NORM_EN defined.
`timescale 1ns/1ps
module tb_bmc_soft_pipe;

`ifdef BMC_NORM_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int CAP = LAT;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [5:0]  rx_sym;
  logic [1:0]  rx_erase;
  logic [15:0] bm, sym_cnt;

  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [1:0]  h_sym, h_erase;
  logic [7:0]  h_bm;
  logic [15:0] h_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  bmc_soft_pipe #(.N(2), .SOFT_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rx_sym(rx_sym), .rx_erase(rx_erase), .out_valid(out_valid),
    .out_ready(out_ready), .bm(bm), .sym_cnt(sym_cnt));

  bmc_soft_pipe #(.N(2), .SOFT_W(1)) dut_h (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .rx_sym(h_sym), .rx_erase(h_erase), .out_valid(h_out_valid),
    .out_ready(h_out_ready), .bm(h_bm), .sym_cnt(h_cnt));

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: distance of every codeword from the received soft bits.
  function automatic logic [15:0] ref_bm(input logic [5:0] sym, input logic [1:0] er);
    int m [4];
    int s;
    logic [15:0] r;
    for (int k = 0; k < 4; k++) begin
      m[k] = 0;
      for (int i = 0; i < 2; i++) begin
        s = int'(sym[i*3 +: 3]);
        if (!er[i]) m[k] += (((k >> i) & 1) == 1) ? (7 - s) : s;
      end
    end
`ifdef BMC_NORM_EN
    begin
      int mn;
      mn = m[0];
      for (int k = 1; k < 4; k++) if (m[k] < mn) mn = m[k];
      for (int k = 0; k < 4; k++) m[k] -= mn;
    end
`endif
    r = '0;
    for (int k = 0; k < 4; k++) r[k*4 +: 4] = 4'(m[k]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one symbol into an empty pipeline and check latency and metrics.
  task automatic single(input logic [5:0] sym, input logic [1:0] er,
                        input logic [15:0] exp_bm, input string name);
    tick();
    in_valid = 1'b1; rx_sym = sym; rx_erase = er; out_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s_in_ready got %b want 1", name, in_ready);
    end
    tick();
    in_valid = 1'b0;
    exp_cnt++;
    #1;
    n_tests++;
    if (sym_cnt !== 16'(exp_cnt)) begin
      n_fail++; $display("FAIL %s_cnt got %0d want %0d", name, sym_cnt, exp_cnt);
    end
    for (int c = 1; c < LAT; c++) begin
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL %s_early out_valid got %b want 0 (cycle %0d)", name, out_valid, c);
      end
      tick();
    end
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL %s_latency out_valid got %b want 1", name, out_valid);
    end
    n_tests++;
    if (bm !== exp_bm) begin
      n_fail++; $display("FAIL %s_bm got %h want %h", name, bm, exp_bm);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_drain out_valid got %b want 0", name, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_tests++;
    if (bm !== 16'h0) begin n_fail++; $display("FAIL reset_bm got %h want 0000", bm); end
    n_tests++;
    if (sym_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", sym_cnt); end
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_tests++;
    if (h_out_valid !== 1'b0 || h_bm !== 8'h0) begin
      n_fail++; $display("FAIL reset_hard got v=%b bm=%h want v=0 bm=00", h_out_valid, h_bm);
    end
  endtask

  task automatic test_soft();
    logic [5:0] s;
    logic [1:0] e;
    // s0=7, s1=0: metrics 7,0,14,7
    single(6'b000_111, 2'b00, {4'd7, 4'd14, 4'd0, 4'd7}, "soft");
    for (int n = 0; n < 4; n++) begin
      s = 6'($urandom_range(0, 63));
      e = 2'($urandom_range(0, 3));
      single(s, e, ref_bm(s, e), "soft_rand");
    end
  endtask

  task automatic test_erase();
    // s0=7, s1=3 erased: metrics 7,0,7,0
    single(6'b011_111, 2'b10, {4'd0, 4'd7, 4'd0, 4'd7}, "erase");
  endtask

  task automatic test_norm();
`ifdef BMC_NORM_EN
    single(6'b100_101, 2'b00, {4'd0, 4'd3, 4'd1, 4'd4}, "norm");
`else
    single(6'b100_101, 2'b00, {4'd5, 4'd8, 4'd6, 4'd9}, "raw");
`endif
    single(6'($urandom_range(0, 63)), 2'b11, 16'h0000, "all_erased");
  endtask

  task automatic test_hard();
    tick();
    h_in_valid = 1'b1; h_sym = 2'b10; h_erase = 2'b00; h_out_ready = 1'b1;
    tick();
    h_in_valid = 1'b0;
    for (int c = 1; c < LAT; c++) tick();
    n_tests++;
    if (h_out_valid !== 1'b1 || h_bm !== {2'd1, 2'd0, 2'd2, 2'd1}) begin
      n_fail++; $display("FAIL hard_hamming got v=%b bm=%h want v=1 bm=%h", h_out_valid, h_bm, {2'd1, 2'd0, 2'd2, 2'd1});
    end
    n_tests++;
    if (h_cnt !== 16'd1) begin n_fail++; $display("FAIL hard_cnt got %0d want 1", h_cnt); end
    tick();
    h_in_valid = 1'b1; h_sym = 2'b11; h_erase = 2'b01;
    tick();
    h_in_valid = 1'b0;
    for (int c = 1; c < LAT; c++) tick();
    n_tests++;
    if (h_out_valid !== 1'b1 || h_bm !== {2'd0, 2'd0, 2'd1, 2'd1}) begin
      n_fail++; $display("FAIL hard_erase got v=%b bm=%h want v=1 bm=%h", h_out_valid, h_bm, {2'd0, 2'd0, 2'd1, 2'd1});
    end
    tick();
  endtask

  // Streaming traffic checked against a queue of reference metrics.
  // mode 0: back-to-back distinct symbols with a fixed stall window; mode 1: random.
  task automatic run_traffic(input int nsym, input int mode, input string name);
    logic [15:0] q[$];
    logic [15:0] prev_bm = '0;
    logic [15:0] want;
    bit          prev_stall = 0;
    bit          saw_full = 0;
    int          sent = 0, got = 0, cyc = 0, start_cnt;
    logic [5:0]  sym;
    logic [1:0]  er;
    start_cnt = exp_cnt;
    sym = (mode == 0) ? 6'd1 : 6'($urandom_range(0, 63));
    er  = (mode == 0) ? 2'b00 : 2'($urandom_range(0, 3));
    while (got < nsym && cyc < 3000) begin
      tick();
      in_valid  = (sent < nsym) && ((mode == 0) || ($urandom_range(0, 3) != 0));
      rx_sym    = sym;
      rx_erase  = er;
      out_ready = (mode == 0) ? !(cyc >= 2 && cyc <= 5) : ($urandom_range(0, 9) < 7);
      #1;
      n_tests++;
      if (in_ready !== ((q.size() < CAP) || out_ready)) begin
        n_fail++; $display("FAIL %s_in_ready cyc %0d got %b want %b (held %0d)", name, cyc, in_ready, ((q.size() < CAP) || out_ready), q.size());
      end
      if (!in_ready) saw_full = 1;
      n_tests++;
      if (sym_cnt !== 16'(exp_cnt)) begin
        n_fail++; $display("FAIL %s_cnt cyc %0d got %0d want %0d", name, cyc, sym_cnt, exp_cnt);
      end
      if (prev_stall) begin
        n_tests++;
        if (out_valid !== 1'b1 || bm !== prev_bm) begin
          n_fail++; $display("FAIL %s_stall_hold cyc %0d got v=%b bm=%h want v=1 bm=%h", name, cyc, out_valid, bm, prev_bm);
        end
      end
      if (out_valid && out_ready) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL %s_spurious cyc %0d got bm=%h want no output", name, cyc, bm);
        end else begin
          want = q.pop_front();
          if (bm !== want) begin
            n_fail++; $display("FAIL %s_order cyc %0d got %h want %h", name, cyc, bm, want);
          end
        end
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_bm    = bm;
      if (in_valid && in_ready) begin
        q.push_back(ref_bm(sym, er));
        sent++;
        exp_cnt++;
        sym = (mode == 0) ? 6'(sent * 9 + 1) : 6'($urandom_range(0, 63));
        er  = (mode == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      end
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_tests++;
    if (got < nsym) begin
      n_fail++; $display("FAIL %s_timeout got %0d outputs want %0d", name, got, nsym);
    end
    tick();
    n_tests++;
    if (sym_cnt !== 16'(start_cnt + nsym)) begin
      n_fail++; $display("FAIL %s_total_cnt got %0d want %0d", name, sym_cnt, start_cnt + nsym);
    end
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_extra out_valid got %b want 0", name, out_valid);
    end
    if (mode == 0) begin
      n_tests++;
      if (!saw_full) begin
        n_fail++; $display("FAIL %s_backpressure in_ready got always 1 want 0 when full", name);
      end
    end
  endtask

  task automatic test_backpressure();
    run_traffic(6, 0, "bp");
  endtask

  task automatic test_random();
    run_traffic(200, 1, "rand");
  endtask

  task automatic test_reset_mid();
    tick();
    in_valid = 1'b1; rx_sym = 6'd12; rx_erase = 2'b00; out_ready = 1'b0;
    tick();
    rx_sym = 6'd33;
    tick();
    in_valid  = 1'b0;
    rst       = 1'b1;
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_handshake out_valid got %b want 0 during reset", out_valid);
    end
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || sym_cnt !== 16'd0 || bm !== 16'h0) begin
      n_fail++; $display("FAIL rst_mid_state got v=%b cnt=%0d bm=%h want v=0 cnt=0 bm=0000", out_valid, sym_cnt, bm);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid_stale cyc %0d out_valid got %b want 0", c, out_valid);
      end
    end
  endtask

  task automatic test_wrap();
    tick();
    in_valid = 1'b1; out_ready = 1'b1;
    rx_sym = 6'($urandom_range(0, 63)); rx_erase = 2'b00;
    repeat (65535) tick();
    n_tests++;
    if (sym_cnt !== 16'd65535) begin
      n_fail++; $display("FAIL wrap_max got %0d want 65535", sym_cnt);
    end
    tick();
    in_valid = 1'b0;
    n_tests++;
    if (sym_cnt !== 16'd0) begin
      n_fail++; $display("FAIL wrap_zero got %0d want 0", sym_cnt);
    end
    repeat (LAT + 1) tick();
    n_tests++;
    if (out_valid !== 1'b0 || sym_cnt !== 16'd0) begin
      n_fail++; $display("FAIL wrap_drain got v=%b cnt=%0d want v=0 cnt=0", out_valid, sym_cnt);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; rx_sym = '0; rx_erase = '0; out_ready = 1'b1;
    h_in_valid = 1'b0; h_sym = '0; h_erase = '0; h_out_ready = 1'b1;
    test_reset();
    test_soft();
    test_erase();
    test_norm();
    test_hard();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
